// File: rtl/store_buffer_pkg.sv
// Shared types for the posted-write store buffer: FSM states, queued entry
// layout and default sizing.
package store_buffer_pkg;

   localparam int SB_DEPTH = 4;
   localparam int SB_AW    = 12;

   typedef enum logic [1:0] {
      RUN,
      FLUSH,
      DONE
   } state_e;

   typedef struct packed {
      logic [SB_AW-3:0] waddr;
      logic [3:0]       be;
      logic [31:0]      data;
      logic [31:0]      pc;
   } entry_t;

endpackage

// File: rtl/store_buffer_if.sv
// Store/load request and data-memory port bundle between the MEM stage,
// the store buffer and the data memory.
interface store_buffer_if;

   logic        st_valid;
   logic        st_ready;
   logic [31:0] st_addr;
   logic [3:0]  st_be;
   logic [31:0] st_data;
   logic [31:0] st_pc;

   logic        ld_valid;
   logic        ld_ready;
   logic [31:0] ld_addr;
   logic [31:0] ld_rdata;

   logic        flush_req;
   logic        flush_done;

   logic [31:0] mem_addr;
   logic [31:0] mem_rd;
   logic        mem_we;
   logic [31:0] mem_wd;
   logic [31:0] mem_pc;

   // The store buffer itself.
   modport slave (
      input  st_valid, st_addr, st_be, st_data, st_pc,
      input  ld_valid, ld_addr, flush_req, mem_rd,
      output st_ready, ld_ready, ld_rdata, flush_done,
      output mem_addr, mem_we, mem_wd, mem_pc
   );

   // The pipeline/memory side that drives requests and read data.
   modport master (
      output st_valid, st_addr, st_be, st_data, st_pc,
      output ld_valid, ld_addr, flush_req, mem_rd,
      input  st_ready, ld_ready, ld_rdata, flush_done,
      input  mem_addr, mem_we, mem_wd, mem_pc
   );

endinterface

// File: rtl/store_buffer_byte_merge.sv
// Per-byte-lane overlay: lanes with en_i set take new_i, the rest keep old_i.
module byte_merge (
   input  logic [31:0] old_i,
   input  logic [31:0] new_i,
   input  logic [3:0]  en_i,
   output logic [31:0] out_o
);

   for (genvar b = 0; b < 4; b++) begin : g_lane
      assign out_o[8*b +: 8] = en_i[b] ? new_i[8*b +: 8] : old_i[8*b +: 8];
   end

endmodule

// File: rtl/store_buffer.sv
// Posted-write store buffer: queues byte-enabled stores, drains one per free
// memory cycle by read-modify-write, and forwards pending bytes to loads.
module store_buffer
   import store_buffer_pkg::*;
#(
   parameter int DEPTH = SB_DEPTH,
   parameter int AW    = SB_AW     // must equal SB_AW: entry_t is sized by it
) (
   input  logic         clk,
   input  logic         rst_n,
   store_buffer_if.slave bus
);

   localparam int             PW   = $clog2(DEPTH);
   localparam int             CW   = PW + 1;
   localparam logic [CW-1:0]  FULL = CW'(DEPTH);

   state_e          state_q;
   logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]   count_q, count_d;
   entry_t          fifo_q [DEPTH];

   entry_t          head;
   logic            st_fire, load_go, drain;
   logic [AW-3:0]   ld_waddr;
   logic [31:0]     drain_wd;
   logic [31:0]     fwd [DEPTH+1];
   logic            unused_st_addr;

   assign head           = fifo_q[rd_ptr_q];
   assign ld_waddr       = bus.ld_addr[AW-1:2];
   assign unused_st_addr = ^{bus.st_addr[31:AW], bus.st_addr[1:0]};

   assign bus.st_ready   = (state_q == RUN) && (count_q != FULL);
   assign st_fire        = bus.st_valid && bus.st_ready;
   // A full buffer keeps the port for draining so a load stream cannot starve it.
   assign load_go        = (state_q == RUN) && bus.ld_valid && (count_q != FULL);
   assign drain          = ((state_q == FLUSH) || ((state_q == RUN) && !load_go))
                           && (count_q != '0);
   assign bus.ld_ready   = load_go;
   assign bus.flush_done = (state_q == DONE);
   assign bus.mem_we     = drain;

   byte_merge u_drain_merge (
      .old_i (bus.mem_rd),
      .new_i (head.data),
      .en_i  (head.be),
      .out_o (drain_wd)
   );

   // Oldest-to-youngest overlay chain, so the youngest matching byte lands last.
   assign fwd[0] = bus.mem_rd;
   for (genvar i = 0; i < DEPTH; i++) begin : g_fwd
      logic [PW-1:0] idx;
      logic [3:0]    en;
      assign idx = rd_ptr_q + PW'(i);
      assign en  = ((CW'(i) < count_q) && (fifo_q[idx].waddr == ld_waddr))
                   ? fifo_q[idx].be : 4'b0000;
      byte_merge u_fwd_merge (
         .old_i (fwd[i]),
         .new_i (fifo_q[idx].data),
         .en_i  (en),
         .out_o (fwd[i+1])
      );
   end

   // NOTE: every output written in always_comb gets a default first, so no
   // path through the block leaves it unassigned and infers a latch.
   always_comb begin
      bus.mem_addr = '0;
      bus.mem_wd   = '0;
      bus.mem_pc   = '0;
      bus.ld_rdata = '0;
      if (load_go) begin
         bus.mem_addr = bus.ld_addr;
         bus.ld_rdata = fwd[DEPTH];
      end else if (drain) begin
         bus.mem_addr = 32'({head.waddr, 2'b00});
         bus.mem_wd   = drain_wd;
         bus.mem_pc   = head.pc;
      end
   end

   always_comb begin
      count_d = count_q;
      if (st_fire && !drain)      count_d = count_q + 1'b1;
      else if (!st_fire && drain) count_d = count_q - 1'b1;
   end

   // NOTE: state registers use non-blocking assignments so every always_ff
   // samples pre-edge values regardless of evaluation order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= RUN;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         count_q <= count_d;
         if (st_fire) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (drain)   rd_ptr_q <= rd_ptr_q + 1'b1;
         unique case (state_q)
            RUN:     if (bus.flush_req) state_q <= (count_d == '0) ? DONE : FLUSH;
            FLUSH:   if (count_d == '0) state_q <= DONE;
            default: state_q <= RUN;
         endcase
      end
   end

   // NOTE: entry storage has no reset; count_q alone decides which slots are
   // live, so stale contents are never observed.
   always_ff @(posedge clk) begin
      if (st_fire) begin
         fifo_q[wr_ptr_q].waddr <= bus.st_addr[AW-1:2];
         fifo_q[wr_ptr_q].be    <= bus.st_be;
         fifo_q[wr_ptr_q].data  <= bus.st_data;
         fifo_q[wr_ptr_q].pc    <= bus.st_pc;
      end
   end

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: queue/array reference model compared
// every cycle, directed scenarios with literal expectations, then random traffic.
`timescale 1ns/1ps
module tb_store_buffer;
   import store_buffer_pkg::*;

   localparam int DEPTH = SB_DEPTH;
   localparam int AW    = SB_AW;
   localparam int WORDS = 1 << (AW - 2);

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   store_buffer_if bif ();

   store_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bif)
   );

   // Data memory: combinational read, written on the clock edge.
   logic [31:0] mem [WORDS];
   assign bif.mem_rd = mem[bif.mem_addr[AW-1:2]];
   always @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < WORDS; i++) mem[i] <= (i == 8) ? 32'hAABB_CCDD : 32'h0;
      end else if (bif.mem_we) begin
         mem[bif.mem_addr[AW-1:2]] <= bif.mem_wd;
      end
   end

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] overlay(input logic [31:0] base, input logic [31:0] d,
                                           input logic [3:0] be);
      for (int b = 0; b < 4; b++) if (be[b]) base[8*b +: 8] = d[8*b +: 8];
      return base;
   endfunction

   // Reference model: pending stores in program order, a shadow memory and
   // the flush mode (0 = run, 1 = flushing, 2 = done pulse).
   typedef struct {
      logic [AW-3:0] w;
      logic [3:0]    be;
      logic [31:0]   d;
      logic [31:0]   pc;
   } st_t;

   st_t         q [$];
   logic [31:0] ref_mem [WORDS];
   int          mode;

   always @(negedge clk) begin : compare
      st_t           h, e;
      bit            e_st, e_ld, e_dr, fire;
      logic [31:0]   e_addr, e_wd, e_pc, e_rd;
      logic [AW-3:0] lw;
      if (!rst_n) begin
         q.delete();
         mode = 0;
         for (int i = 0; i < WORDS; i++) ref_mem[i] = (i == 8) ? 32'hAABB_CCDD : 32'h0;
      end
      e_st   = (mode == 0) && (q.size() < DEPTH);
      e_ld   = (mode == 0) && bif.ld_valid && (q.size() < DEPTH);
      e_dr   = (q.size() > 0) && ((mode == 1) || ((mode == 0) && !e_ld));
      e_addr = '0; e_wd = '0; e_pc = '0; e_rd = '0;
      if (e_ld) begin
         lw     = bif.ld_addr[AW-1:2];
         e_rd   = ref_mem[lw];
         foreach (q[i]) if (q[i].w == lw) e_rd = overlay(e_rd, q[i].d, q[i].be);
         e_addr = bif.ld_addr;
      end else if (e_dr) begin
         h      = q[0];
         e_wd   = overlay(ref_mem[h.w], h.d, h.be);
         e_addr = 32'({h.w, 2'b00});
         e_pc   = h.pc;
      end
      check("st_ready",   32'(bif.st_ready),   32'(e_st));
      check("ld_ready",   32'(bif.ld_ready),   32'(e_ld));
      check("mem_we",     32'(bif.mem_we),     32'(e_dr));
      check("flush_done", 32'(bif.flush_done), 32'(mode == 2));
      check("mem_addr",   bif.mem_addr,        e_addr);
      check("mem_wd",     bif.mem_wd,          e_wd);
      check("mem_pc",     bif.mem_pc,          e_pc);
      check("ld_rdata",   bif.ld_rdata,        e_rd);
      if (rst_n) begin
         fire = bif.st_valid && e_st;
         if (e_dr) begin
            ref_mem[h.w] = e_wd;
            void'(q.pop_front());
         end
         if (fire) begin
            e.w  = bif.st_addr[AW-1:2];
            e.be = bif.st_be;
            e.d  = bif.st_data;
            e.pc = bif.st_pc;
            q.push_back(e);
         end
         case (mode)
            0:       if (bif.flush_req) mode = (q.size() == 0) ? 2 : 1;
            1:       if (q.size() == 0) mode = 2;
            default: mode = 0;
         endcase
      end
   end

   task automatic idle_in();
      bif.st_valid  = 1'b0;
      bif.st_addr   = '0;
      bif.st_be     = '0;
      bif.st_data   = '0;
      bif.st_pc     = '0;
      bif.ld_valid  = 1'b0;
      bif.ld_addr   = '0;
      bif.flush_req = 1'b0;
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
      idle_in();
   endtask

   task automatic store(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d,
                        input logic [31:0] pc);
      bif.st_valid = 1'b1;
      bif.st_addr  = a;
      bif.st_be    = be;
      bif.st_data  = d;
      bif.st_pc    = pc;
   endtask

   task automatic load(input logic [31:0] a);
      bif.ld_valid = 1'b1;
      bif.ld_addr  = a;
   endtask

   task automatic rand_inputs();
      int unsigned pick;
      logic [3:0]  be;
      pick = $urandom_range(0, 6);
      case (pick)
         0:       be = 4'b1111;
         1:       be = 4'b0011;
         2:       be = 4'b1100;
         default: be = 4'(1 << (pick - 3));
      endcase
      if ($urandom_range(0, 1) == 1)
         store((32'($urandom_range(0, 15)) << 12) | (32'($urandom_range(0, 15)) << 2)
               | 32'($urandom_range(0, 3)), be, $urandom, $urandom);
      if ($urandom_range(0, 9) < 4)
         load((32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3)));
      bif.flush_req = ($urandom_range(0, 19) == 0);
   endtask

   initial begin
      idle_in();
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #3;
      check("rst_st_ready",   32'(bif.st_ready),   32'd1);
      check("rst_ld_ready",   32'(bif.ld_ready),   32'd0);
      check("rst_flush_done", 32'(bif.flush_done), 32'd0);
      check("rst_mem_we",     32'(bif.mem_we),     32'd0);
      check("rst_mem_addr",   bif.mem_addr,        32'h0);
      check("rst_mem_wd",     bif.mem_wd,          32'h0);
      check("rst_mem_pc",     bif.mem_pc,          32'h0);
      check("rst_ld_rdata",   bif.ld_rdata,        32'h0);
      @(posedge clk);
      #1 rst_n = 1'b1;

      // sw drains in the cycle after acceptance
      store(32'h10, 4'b1111, 32'h1122_3344, 32'h100);
      #2 check("sw_accept", 32'(bif.st_ready), 32'd1);
      cyc();
      #2;
      check("sw_drain_we",   32'(bif.mem_we), 32'd1);
      check("sw_drain_addr", bif.mem_addr,    32'h10);
      check("sw_drain_wd",   bif.mem_wd,      32'h1122_3344);
      check("sw_drain_pc",   bif.mem_pc,      32'h100);

      // sb merged into existing word 0xAABBCCDD
      cyc();
      store(32'h20, 4'b0100, 32'h00EE_0000, 32'h104);
      cyc();
      #2;
      check("sb_merge_addr", bif.mem_addr, 32'h20);
      check("sb_merge_wd",   bif.mem_wd,   32'hAAEE_CCDD);

      // forwarding: youngest bytes win, same-cycle enqueue ignored
      cyc();
      store(32'h30, 4'b1111, 32'h1111_1111, 32'h108);
      load(32'h40);
      cyc();
      store(32'h30, 4'b0011, 32'h0000_2222, 32'h10C);
      load(32'h30);
      #2 check("fwd_same_cycle", bif.ld_rdata, 32'h1111_1111);
      cyc();
      load(32'h30);
      #2;
      check("fwd_merge_data",  bif.ld_rdata,      32'h1111_2222);
      check("fwd_merge_ready", 32'(bif.ld_ready), 32'd1);
      check("fwd_merge_no_we", 32'(bif.mem_we),   32'd0);
      repeat (3) cyc();

      // full buffer with a continuous load stream still drains
      for (int i = 0; i < 4; i++) begin
         cyc();
         store(32'h40 + 32'(4 * i), 4'b1111, 32'(i), 32'h200 + 32'(4 * i));
         load(32'h80);
      end
      cyc();
      load(32'h80);
      #2;
      check("full_st_ready",  32'(bif.st_ready), 32'd0);
      check("full_ld_ready",  32'(bif.ld_ready), 32'd0);
      check("full_drain_we",  32'(bif.mem_we),   32'd1);
      check("full_drain_adr", bif.mem_addr,      32'h40);
      cyc();
      load(32'h80);
      #2;
      check("after_full_ld_ready", 32'(bif.ld_ready), 32'd1);
      check("after_full_no_we",    32'(bif.mem_we),   32'd0);
      repeat (5) cyc();

      // flush with three pending entries
      for (int i = 0; i < 3; i++) begin
         cyc();
         store(32'h50 + 32'(4 * i), 4'b1111, 32'hF0 + 32'(i), 32'h300);
         load(32'h80);
      end
      cyc();
      bif.flush_req = 1'b1;
      #2 check("flush_we0", 32'(bif.mem_we), 32'd1);
      cyc();
      #2;
      check("flush_st_ready1", 32'(bif.st_ready), 32'd0);
      check("flush_we1",       32'(bif.mem_we),   32'd1);
      cyc();
      #2;
      check("flush_st_ready2", 32'(bif.st_ready), 32'd0);
      check("flush_we2",       32'(bif.mem_we),   32'd1);
      cyc();
      #2;
      check("flush_done_hi", 32'(bif.flush_done), 32'd1);
      check("flush_done_we", 32'(bif.mem_we),     32'd0);
      cyc();
      #2;
      check("flush_done_lo",   32'(bif.flush_done), 32'd0);
      check("flush_resume_rd", 32'(bif.st_ready),   32'd1);

      // flush with an empty buffer
      cyc();
      bif.flush_req = 1'b1;
      #2 check("flush0_req_cycle", 32'(bif.flush_done), 32'd0);
      cyc();
      #2;
      check("flush0_done_hi",  32'(bif.flush_done), 32'd1);
      check("flush0_st_ready", 32'(bif.st_ready),   32'd0);
      cyc();
      #2 check("flush0_done_lo", 32'(bif.flush_done), 32'd0);

      // asynchronous reset mid-cycle with two entries pending
      for (int i = 0; i < 2; i++) begin
         cyc();
         store(32'h60 + 32'(4 * i), 4'b1111, 32'hDEAD_0000 + 32'(i), 32'h400);
         load(32'h80);
      end
      cyc();
      #2 rst_n = 1'b0;
      #1;
      check("arst_st_ready", 32'(bif.st_ready), 32'd1);
      check("arst_mem_we",   32'(bif.mem_we),   32'd0);
      cyc();
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         cyc();
         #2 check("arst_no_we", 32'(bif.mem_we), 32'd0);
      end

      repeat (1500) begin
         cyc();
         rand_inputs();
      end
      repeat (10) cyc();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
